// File: rtl/level_det_pkg.sv
// Shared FSM encodings and default widths for the level/event detector.
package level_det_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_QUAL = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_QUAL = 2'd3
  } state_t;

  localparam int LEN_W_DEF = 16;
  localparam int DEB_W_DEF = 4;

endpackage

// File: rtl/level_event_detector.sv
// Hysteresis/debounce level detector emitting {peak,len} records; level_high and record 1 cycle after the deciding sample.
// Single-entry record with valid/ready: a completion while the record is stalled is dropped and flagged in sticky overflow.
module level_event_detector
  import level_det_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int DEB_W = DEB_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             in_valid,
  input  logic [7:0]       cfg_thr_hi,
  input  logic [7:0]       cfg_thr_lo,
  input  logic [DEB_W-1:0] cfg_debounce,
  output logic             level_high,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_peak,
  output logic [LEN_W-1:0] evt_len,
  output logic             overflow
);

  localparam logic [DEB_W:0] DEB_ONE = (DEB_W+1)'(1);

  state_t           state;
  logic [DEB_W-1:0] qual_cnt;
  logic [7:0]       peak;
  logic [LEN_W-1:0] len;

  logic [DEB_W:0]   eff_deb;
  logic [DEB_W:0]   cnt_inc;
  logic             rise_q;
  logic             fall_q;
  logic             emit;
  logic [7:0]       peak_nxt;
  logic [LEN_W-1:0] len_nxt;

  // peak_nxt/len_nxt already include the current sample, so they are what an emitted record carries
  always_comb begin
    eff_deb  = (cfg_debounce == '0) ? DEB_ONE : {1'b0, cfg_debounce};
    cnt_inc  = {1'b0, qual_cnt} + DEB_ONE;
    rise_q   = (data_in >= cfg_thr_hi);
    fall_q   = (data_in <= cfg_thr_lo);
    peak_nxt = (data_in > peak) ? data_in : peak;
    len_nxt  = (&len) ? len : len + LEN_W'(1);
    emit     = 1'b0;
    if (in_valid && fall_q) begin
      if (state == ST_HIGH && eff_deb == DEB_ONE) emit = 1'b1;
      if (state == ST_FALL_QUAL && cnt_inc >= eff_deb) emit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOW;
      qual_cnt   <= '0;
      peak       <= '0;
      len        <= '0;
      level_high <= 1'b0;
    end else if (in_valid) begin
      case (state)
        ST_LOW: begin
          if (rise_q) begin
            peak <= data_in;
            len  <= LEN_W'(1);
            if (eff_deb == DEB_ONE) begin
              state      <= ST_HIGH;
              level_high <= 1'b1;
              qual_cnt   <= '0;
            end else begin
              state    <= ST_RISE_QUAL;
              qual_cnt <= DEB_W'(1);
            end
          end
        end
        ST_RISE_QUAL: begin
          if (rise_q) begin
            peak <= peak_nxt;
            len  <= len_nxt;
            if (cnt_inc >= eff_deb) begin
              state      <= ST_HIGH;
              level_high <= 1'b1;
              qual_cnt   <= '0;
            end else begin
              qual_cnt <= cnt_inc[DEB_W-1:0];
            end
          end else begin
            state    <= ST_LOW;
            qual_cnt <= '0;
            peak     <= '0;
            len      <= '0;
          end
        end
        ST_HIGH: begin
          peak <= peak_nxt;
          len  <= len_nxt;
          if (fall_q) begin
            if (eff_deb == DEB_ONE) begin
              state      <= ST_LOW;
              level_high <= 1'b0;
              qual_cnt   <= '0;
              peak       <= '0;
              len        <= '0;
            end else begin
              state    <= ST_FALL_QUAL;
              qual_cnt <= DEB_W'(1);
            end
          end
        end
        ST_FALL_QUAL: begin
          peak <= peak_nxt;
          len  <= len_nxt;
          if (fall_q) begin
            if (cnt_inc >= eff_deb) begin
              state      <= ST_LOW;
              level_high <= 1'b0;
              qual_cnt   <= '0;
              peak       <= '0;
              len        <= '0;
            end else begin
              qual_cnt <= cnt_inc[DEB_W-1:0];
            end
          end else begin
            state    <= ST_HIGH;
            qual_cnt <= '0;
          end
        end
        default: state <= ST_LOW;
      endcase
    end
  end

  // The pending record is never overwritten; a collision only sets overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_peak  <= '0;
      evt_len   <= '0;
      overflow  <= 1'b0;
    end else if (emit && (!evt_valid || evt_ready)) begin
      evt_valid <= 1'b1;
      evt_peak  <= peak_nxt;
      evt_len   <= len_nxt;
    end else begin
      if (emit) overflow <= 1'b1;
      if (evt_ready) evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_level_event_detector.sv
// Directed vector table plus hand-written multi-cycle sequences for level_event_detector.
module tb_level_event_detector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        in_valid;
  logic [7:0]  cfg_thr_hi;
  logic [7:0]  cfg_thr_lo;
  logic [3:0]  cfg_debounce;
  logic        level_high;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_peak;
  logic [15:0] evt_len;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;
  int hs_cnt = 0;

  level_event_detector dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .cfg_thr_hi(cfg_thr_hi), .cfg_thr_lo(cfg_thr_lo), .cfg_debounce(cfg_debounce),
    .level_high(level_high), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_peak(evt_peak), .evt_len(evt_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && evt_valid && evt_ready) hs_cnt++;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [3:0]  deb;
    logic        iv;
    logic [7:0]  d;
    logic        rdy;
    logic        lh;
    logic        vld;
    logic [7:0]  pk;
    logic [15:0] ln;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] hi, input logic [7:0] lo, input logic [3:0] deb,
                              input logic iv, input logic [7:0] d, input logic lh,
                              input logic vld, input logic [7:0] pk, input logic [15:0] ln);
    vec_t v;
    v.hi = hi; v.lo = lo; v.deb = deb; v.iv = iv; v.d = d; v.rdy = 1'b1;
    v.lh = lh; v.vld = vld; v.pk = pk; v.ln = ln;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] d, input logic rdy);
    in_valid  = iv;
    data_in   = d;
    evt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " level_high"}, int'(level_high), 0);
    chk({tag, " evt_valid"}, int'(evt_valid), 0);
    chk({tag, " evt_peak"}, int'(evt_peak), 0);
    chk({tag, " evt_len"}, int'(evt_len), 0);
    chk({tag, " overflow"}, int'(overflow), 0);
  endtask

  initial begin
    int hs0;
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; evt_ready = 1'b1;
    cfg_thr_hi = 8'd100; cfg_thr_lo = 8'd60; cfg_debounce = 4'd3;

    // basic stream, debounce 3
    tbl.push_back(mk(100, 60, 3, 1,  50, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1, 110, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1, 120, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1, 130, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1, 140, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1,  90, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1,  50, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1,  40, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1,  30, 0, 1, 140, 8));
    tbl.push_back(mk(100, 60, 3, 0,   0, 0, 0,   0, 0));
    // aborted rise
    tbl.push_back(mk(100, 60, 3, 1,  50, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1, 110, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1, 120, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1,  50, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1,  50, 0, 0,   0, 0));
    // same stream with in_valid gaps
    tbl.push_back(mk(100, 60, 3, 1,  50, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1, 110, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 0, 255, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1, 120, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 0,   5, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 0, 250, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1, 130, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 0,   0, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1, 140, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1,  90, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 0, 200, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1,  50, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1,  40, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 0,  10, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 3, 1,  30, 0, 1, 140, 8));
    tbl.push_back(mk(100, 60, 3, 0,   0, 0, 0,   0, 0));
    // threshold equality, debounce 1
    tbl.push_back(mk(100, 60, 1, 1,  99, 0, 0,   0, 0));
    tbl.push_back(mk(100, 60, 1, 1, 100, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 1, 1,  61, 1, 0,   0, 0));
    tbl.push_back(mk(100, 60, 1, 1,  60, 0, 1, 100, 3));
    tbl.push_back(mk(100, 60, 1, 0,   0, 0, 0,   0, 0));

    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      cfg_thr_hi = tbl[i].hi; cfg_thr_lo = tbl[i].lo; cfg_debounce = tbl[i].deb;
      step(tbl[i].iv, tbl[i].d, tbl[i].rdy);
      chk($sformatf("vec%0d level_high", i), int'(level_high), int'(tbl[i].lh));
      chk($sformatf("vec%0d evt_valid", i), int'(evt_valid), int'(tbl[i].vld));
      chk($sformatf("vec%0d overflow", i), int'(overflow), 0);
      if (tbl[i].vld) begin
        chk($sformatf("vec%0d evt_peak", i), int'(evt_peak), int'(tbl[i].pk));
        chk($sformatf("vec%0d evt_len", i), int'(evt_len), int'(tbl[i].ln));
      end
    end

    // two events against a stalled consumer
    cfg_thr_hi = 8'd100; cfg_thr_lo = 8'd60; cfg_debounce = 4'd1;
    hs0 = hs_cnt;
    step(1, 150, 0);
    step(1, 200, 0);
    step(1,  50, 0);
    chk("ovf first valid", int'(evt_valid), 1);
    chk("ovf first peak", int'(evt_peak), 200);
    chk("ovf first len", int'(evt_len), 3);
    chk("ovf not yet", int'(overflow), 0);
    step(1, 120, 0);
    step(1,  10, 0);
    chk("ovf held valid", int'(evt_valid), 1);
    chk("ovf held peak", int'(evt_peak), 200);
    chk("ovf held len", int'(evt_len), 3);
    chk("ovf set", int'(overflow), 1);
    chk("ovf no handshake while stalled", hs_cnt - hs0, 0);
    step(0, 0, 1);
    chk("ovf drained valid", int'(evt_valid), 0);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("ovf single handshake", hs_cnt - hs0, 1);
    chk("ovf sticky", int'(overflow), 1);

    // reset while HIGH
    cfg_debounce = 4'd3;
    hs0 = hs_cnt;
    step(1, 110, 1);
    step(1, 120, 1);
    step(1, 130, 1);
    step(1, 140, 1);
    chk("pre-reset level_high", int'(level_high), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid-event reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 30, 1);
    step(1, 30, 1);
    step(1, 30, 1);
    step(0, 0, 1);
    chk("post-reset no event", int'(evt_valid), 0);
    chk("post-reset level_high", int'(level_high), 0);
    chk("post-reset handshakes", hs_cnt - hs0, 0);

    // length saturation with debounce 0
    cfg_debounce = 4'd0;
    step(1, 200, 1);
    chk("deb0 immediate high", int'(level_high), 1);
    for (int k = 1; k < 70000; k++) step(1, 200, 1);
    chk("sat no event yet", int'(evt_valid), 0);
    step(1, 10, 1);
    chk("sat valid", int'(evt_valid), 1);
    chk("sat len", int'(evt_len), 65535);
    chk("sat peak", int'(evt_peak), 200);
    chk("sat level_high", int'(level_high), 0);
    step(0, 0, 1);
    chk("sat drained", int'(evt_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/level_event_detector.md
LEVEL_EVENT_DETECTOR -- requirements
Module: level_event_detector

Interface
REQ-001 Parameter LEN_W, default 16: width of the event-length counter.
REQ-002 Parameter DEB_W, default 4: width of the debounce configuration and counter.
REQ-003 clk  input  1  sole clock; all logic is rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  8  filtered sample from the upstream median filter, unsigned.
REQ-006 in_valid  input  1  data_in is a new sample this cycle (tie high for every-clock streams).
REQ-007 cfg_thr_hi  input  8  rise threshold; qualifies when sample >= cfg_thr_hi.
REQ-008 cfg_thr_lo  input  8  fall threshold; qualifies when sample <= cfg_thr_lo.
REQ-009 cfg_debounce  input  DEB_W  consecutive qualifying samples needed; 0 behaves as 1.
REQ-010 level_high  output  1  registered, high while in HIGH or FALL_QUAL.
REQ-011 evt_valid  output  1  completed-event record available.
REQ-012 evt_ready  input  1  consumer accepts record when evt_valid && evt_ready.
REQ-013 evt_peak  output  8  maximum sample within the event.
REQ-014 evt_len  output  LEN_W  number of samples in the event, saturating.
REQ-015 overflow  output  1  sticky; an event was dropped because the record was still pending.

Function
REQ-016 The FSM SHALL have states LOW, RISE_QUAL, HIGH, FALL_QUAL and advance only on in_valid=1 cycles; in_valid=0 freezes state, counters, peak and length.
REQ-017 LOW: a rise-qualifying sample SHALL go to RISE_QUAL with qual_cnt=1 (directly to HIGH if effective debounce is 1); peak and length restart with that sample.
REQ-018 RISE_QUAL: a rise-qualifying sample increments qual_cnt and SHALL enter HIGH when qual_cnt reaches the effective debounce; a non-qualifying sample returns to LOW and discards peak/length.
REQ-019 HIGH: a fall-qualifying sample SHALL go to FALL_QUAL with qual_cnt=1 (directly to LOW with event emission if effective debounce is 1).
REQ-020 FALL_QUAL: a fall-qualifying sample increments qual_cnt and SHALL return to LOW, emitting an event, when qual_cnt reaches the effective debounce; a non-qualifying sample returns to HIGH.
REQ-021 Length SHALL count every accepted sample from the first rise-qualifying sample through the final fall-qualifying sample inclusive, saturating at 2^LEN_W-1.
REQ-022 Peak SHALL be the unsigned maximum over the same sample span.
REQ-023 level_high SHALL rise the cycle after the sample completing rise qualification and fall the cycle after the sample completing fall qualification.
REQ-024 On emission, evt_peak/evt_len SHALL load and evt_valid assert the following cycle if evt_valid=0, or if evt_valid=1 and evt_ready=1 in the emission cycle.
REQ-025 If evt_valid=1 and evt_ready=0 at emission, the new event SHALL be dropped, the pending record held unchanged, and overflow set.
REQ-026 evt_valid SHALL deassert the cycle after acceptance unless reloaded per REQ-024; payload SHALL be stable while evt_valid=1.
REQ-027 Configuration SHALL be sampled on each accepted sample; thr_lo >= thr_hi is not checked, and comparisons apply as stated.

Reset
REQ-028 rst_n low SHALL immediately force state LOW, qual_cnt 0, peak 0, length 0, level_high 0, evt_valid 0, evt_peak 0, evt_len 0, overflow 0.
REQ-029 Reset mid-event SHALL discard the event without emission; overflow clears only by reset.

Structure
REQ-030 The FSM state encodings and default LEN_W/DEB_W constants SHALL live in shared package level_det_pkg.
REQ-031 The block SHALL be one module with no sub-module; the output record register is inline.

Verification
REQ-032 hi=100, lo=60, deb=3, ready=1; stream 50,110,120,130,140,90,50,40,30 -> level_high rises after 130, one event peak=140 len=8.
REQ-033 Same config; stream 50,110,120,50,50 -> level_high stays 0, no evt_valid.
REQ-034 evt_ready=0, two complete events -> first record held unchanged, overflow=1, second lost; ready=1 -> single handshake.
REQ-035 deb=0, hi=100, lo=60; 70000 samples of 200 then 10 -> evt_len=65535, peak=200.
REQ-036 Interleave in_valid=0 cycles inside REQ-032 stream -> identical event; rst_n low during HIGH -> all outputs 0, no event.
